cam_capture_ctrl: RTL and testbench

- Frame-capture sequencer for the OV7670 capture path.
- Arms on request and aligns to a VSYNC frame boundary.
- During active lines it tells the RGB565→RGB332 packer which byte is on the bus, and generates the write strobe and pixel address for the dual-port frame RAM.
- Counts pixels and lines, detects malformed frames, reports completion to the host/VGA side. Single or continuous capture.

---
 rtl/cam_capture_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_cam_capture_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_capture_ctrl.sv
// -----------------------------------------------------------------------------
// cam_capture_ctrl
// Frame-capture sequencer for the OV7670 capture path. It arms on a host
// request, aligns to a VSYNC frame boundary and, during active lines, tells
// the RGB565->RGB332 packer which byte is on the camera bus. It also produces
// the per-pixel write strobe and address for the dual-port frame RAM, counts
// pixels and lines, flags malformed frames and reports completion.
//
// Ports
//   PCLK            camera pixel clock (sole clock)
//   rst_n           synchronous active-low reset
//   VSYNC, HREF     camera sync inputs, PCLK-synchronous
//   start           one-cycle capture request (honoured only in IDLE)
//   cont_mode       1 = re-arm automatically after each frame
//   abort           one-cycle abort, returns to IDLE
//   byte_phase      0 = first byte of a pixel, 1 = second byte
//   DP_RAM_addr_in  pixel address for the RAM write
//   DP_RAM_regW     RAM write enable, one cycle per stored pixel
//   busy            high in every state except IDLE
//   frame_done      one-cycle pulse at end of frame
//   line_err        sticky malformed-frame / overflow flag
//   frame_count     completed frames, wraps 255 -> 0
//   state_dbg_o     current FSM state encoding, for observation only
//
// Handshake: there is no back-pressure. A pixel is complete on a cycle with
// HREF=1 and byte_phase=1; the cycle after, DP_RAM_regW is high for exactly
// one cycle with DP_RAM_addr_in holding that pixel's index, and the RAM must
// accept it in that cycle.
// -----------------------------------------------------------------------------
module cam_capture_ctrl #(
    parameter int H_PIX   = 160,
    parameter int V_LINES = 120,
    parameter int AW      = 15
) (
    input  logic          PCLK,
    input  logic          rst_n,
    input  logic          VSYNC,
    input  logic          HREF,
    input  logic          start,
    input  logic          cont_mode,
    input  logic          abort,
    output logic          byte_phase,
    output logic [AW-1:0] DP_RAM_addr_in,
    output logic          DP_RAM_regW,
    output logic          busy,
    output logic          frame_done,
    output logic          line_err,
    output logic [7:0]    frame_count,
    output logic [2:0]    state_dbg_o
);

    localparam int TOTAL = H_PIX * V_LINES;
    // Pixel counter saturates one above H_PIX so over-long lines stay detectable.
    localparam int PW    = $clog2(H_PIX + 2);
    localparam int LW    = $clog2(V_LINES + 1);

    localparam logic [AW-1:0] LAST_ADDR = AW'(TOTAL - 1);
    localparam logic [PW-1:0] PIX_LINE  = PW'(H_PIX);
    localparam logic [PW-1:0] PIX_SAT   = PW'(H_PIX + 1);
    localparam logic [LW-1:0] LINE_LAST = LW'(V_LINES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARM    = 3'd1,
        S_SYNC   = 3'd2,
        S_ACTIVE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic          vsync_q, href_q;
    logic          bp_q, bp_d;
    logic [PW-1:0] pix_cnt_q, pix_cnt_d;
    logic [LW-1:0] line_cnt_q, line_cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          regw_q, regw_d;
    logic          full_q, full_d;
    logic          line_err_q, line_err_d;
    logic [7:0]    frame_cnt_q, frame_cnt_d;

    logic vs_rise, vs_fall, href_fall;

    assign vs_rise   = VSYNC & ~vsync_q;
    assign vs_fall   = ~VSYNC & vsync_q;
    assign href_fall = ~HREF & href_q;

    always_ff @(posedge PCLK) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            vsync_q     <= 1'b0;
            href_q      <= 1'b0;
            bp_q        <= 1'b0;
            pix_cnt_q   <= '0;
            line_cnt_q  <= '0;
            addr_q      <= '0;
            regw_q      <= 1'b0;
            full_q      <= 1'b0;
            line_err_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            vsync_q     <= VSYNC;
            href_q      <= HREF;
            bp_q        <= bp_d;
            pix_cnt_q   <= pix_cnt_d;
            line_cnt_q  <= line_cnt_d;
            addr_q      <= addr_d;
            regw_q      <= regw_d;
            full_q      <= full_d;
            line_err_q  <= line_err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bp_d        = 1'b0;
        pix_cnt_d   = pix_cnt_q;
        line_cnt_d  = line_cnt_q;
        addr_d      = addr_q;
        regw_d      = 1'b0;
        full_d      = full_q;
        line_err_d  = line_err_q;
        frame_cnt_d = frame_cnt_q;

        // Address advances the cycle after each write; the last RAM slot is
        // held and marks the frame buffer as full.
        if (regw_q) begin
            if (addr_q == LAST_ADDR) begin
                full_d = 1'b1;
            end else begin
                addr_d = addr_q + AW'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_ARM;
                    line_err_d = 1'b0;
                end
            end
            S_ARM: begin
                if (vs_rise) begin
                    state_d = S_SYNC;
                end
            end
            S_SYNC: begin
                pix_cnt_d  = '0;
                line_cnt_d = '0;
                addr_d     = '0;
                full_d     = 1'b0;
                if (vs_fall) begin
                    state_d = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (HREF) begin
                    bp_d = ~bp_q;
                    if (bp_q) begin
                        if (full_q) begin
                            line_err_d = 1'b1;
                        end else begin
                            regw_d = 1'b1;
                        end
                        if (pix_cnt_q != PIX_SAT) begin
                            pix_cnt_d = pix_cnt_q + PW'(1);
                        end
                    end
                end
                if (href_fall) begin
                    pix_cnt_d  = '0;
                    line_cnt_d = line_cnt_q + LW'(1);
                    if (pix_cnt_q != PIX_LINE) begin
                        line_err_d = 1'b1;
                    end
                    if (line_cnt_q == LINE_LAST) begin
                        state_d = S_DONE;
                    end
                end
                // A new VSYNC before the frame is complete truncates it.
                if (vs_rise && (state_d != S_DONE)) begin
                    line_err_d = 1'b1;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                frame_cnt_d = frame_cnt_q + 8'd1;
                state_d     = cont_mode ? S_SYNC : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort) begin
            state_d = S_IDLE;
            regw_d  = 1'b0;
        end

        // byte_phase only runs while the line stays inside ACTIVE.
        if (state_d != S_ACTIVE) begin
            bp_d = 1'b0;
        end
    end

    // Abort must also cancel a write already queued for this cycle.
    assign DP_RAM_regW    = regw_q & ~abort;
    assign DP_RAM_addr_in = addr_q;
    assign byte_phase     = bp_q;
    assign busy           = (state_q != S_IDLE);
    assign frame_done     = (state_q == S_DONE);
    assign line_err       = line_err_q;
    assign frame_count    = frame_cnt_q;
    assign state_dbg_o    = state_q;

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cam_capture_ctrl
// Directed bench for cam_capture_ctrl with a tiny frame (4 pixels x 2 lines).
// Stimulus tasks push the expected RAM write addresses and end-of-frame
// line_err values into queues; a negedge monitor pops and compares whenever
// the DUT presents a write strobe or a frame_done pulse.
// -----------------------------------------------------------------------------
module tb_cam_capture_ctrl;

    localparam int H_PIX   = 4;
    localparam int V_LINES = 2;
    localparam int AW      = 15;

    logic          PCLK = 1'b0;
    logic          rst_n;
    logic          VSYNC;
    logic          HREF;
    logic          start;
    logic          cont_mode;
    logic          abort;
    logic          byte_phase;
    logic [AW-1:0] DP_RAM_addr_in;
    logic          DP_RAM_regW;
    logic          busy;
    logic          frame_done;
    logic          line_err;
    logic [7:0]    frame_count;
    logic [2:0]    state_dbg_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic [AW-1:0] exp_q[$];
    logic          exp_done_q[$];

    cam_capture_ctrl #(
        .H_PIX   (H_PIX),
        .V_LINES (V_LINES),
        .AW      (AW)
    ) dut (
        .PCLK           (PCLK),
        .rst_n          (rst_n),
        .VSYNC          (VSYNC),
        .HREF           (HREF),
        .start          (start),
        .cont_mode      (cont_mode),
        .abort          (abort),
        .byte_phase     (byte_phase),
        .DP_RAM_addr_in (DP_RAM_addr_in),
        .DP_RAM_regW    (DP_RAM_regW),
        .busy           (busy),
        .frame_done     (frame_done),
        .line_err       (line_err),
        .frame_count    (frame_count),
        .state_dbg_o    (state_dbg_o)
    );

    // ---------------- clock ----------------
    always #5 PCLK = ~PCLK;

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor: outputs are sampled on the falling edge.
    always @(negedge PCLK) begin
        if (rst_n === 1'b1) begin
            if (DP_RAM_regW !== 1'b0) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_write: got write at addr %0d, expected none", DP_RAM_addr_in);
                end else begin
                    check("write_addr", DP_RAM_addr_in, exp_q.pop_front());
                end
            end
            if (frame_done !== 1'b0) begin
                if (exp_done_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done: got frame_done, expected none");
                end else begin
                    check("done_line_err", line_err, exp_done_q.pop_front());
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic drive(input logic vs, input logic hr, input logic st, input logic ab);
        @(posedge PCLK);
        #1;
        VSYNC = vs;
        HREF  = hr;
        start = st;
        abort = ab;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_start();
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic vsync_pulse();
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
        idle(3);
    endtask

    // One HREF burst of nbytes, expecting nwrites writes from first_addr on.
    task automatic send_line(input int nbytes, input int first_addr, input int nwrites);
        for (int i = 0; i < nwrites; i++) exp_q.push_back(AW'(first_addr + i));
        for (int i = 0; i < nbytes; i++) drive(1'b0, 1'b1, 1'b0, 1'b0);
        idle(4);
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},     busy,           0);
        check({tag, "_regw"},     DP_RAM_regW,    0);
        check({tag, "_addr"},     DP_RAM_addr_in, 0);
        check({tag, "_done"},     frame_done,     0);
        check({tag, "_line_err"}, line_err,       0);
        check({tag, "_fcount"},   frame_count,    0);
        check({tag, "_bphase"},   byte_phase,     0);
        check({tag, "_state"},    state_dbg_o,    0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n     = 1'b0;
        VSYNC     = 1'b0;
        HREF      = 1'b0;
        start     = 1'b0;
        cont_mode = 1'b0;
        abort     = 1'b0;
        idle(3);
        rst_n = 1'b1;
        check_all_zero("reset");

        // Nominal frame with explicit frame_done timing.
        do_start();
        check("t1_busy_after_start", busy, 1);
        vsync_pulse();
        send_line(8, 0, 4);
        exp_done_q.push_back(1'b0);
        for (int i = 0; i < 4; i++) exp_q.push_back(AW'(4 + i));
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge PCLK);
        check("t1_done_not_yet", frame_done, 0);
        @(negedge PCLK);
        check("t1_done_pulse", frame_done, 1);
        @(negedge PCLK);
        check("t1_done_one_cycle", frame_done, 0);
        check("t1_fcount", frame_count, 1);
        check("t1_busy_low", busy, 0);
        check("t1_line_err", line_err, 0);
        idle(2);

        // Start mid-frame: HREF activity before any VSYNC is ignored.
        do_start();
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge PCLK);
        check("t2_bphase_in_arm", byte_phase, 0);
        check("t2_busy_in_arm", busy, 1);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 1'b0);
        idle(4);
        send_line(8, 0, 0);
        vsync_pulse();
        exp_done_q.push_back(1'b0);
        send_line(8, 0, 4);
        send_line(8, 4, 4);
        check("t2_fcount", frame_count, 2);

        // Short line: 6 bytes gives 3 pixels, next line continues at 3.
        do_start();
        vsync_pulse();
        send_line(6, 0, 3);
        check("t3_err_after_short", line_err, 1);
        exp_done_q.push_back(1'b1);
        send_line(8, 3, 4);
        check("t3_err_sticky", line_err, 1);
        check("t3_fcount", frame_count, 3);

        // Early VSYNC after one line truncates the frame.
        do_start();
        check("t4_err_cleared_by_start", line_err, 0);
        vsync_pulse();
        send_line(8, 0, 4);
        exp_done_q.push_back(1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        idle(3);
        send_line(8, 0, 0);
        check("t4_busy_low", busy, 0);
        check("t4_fcount", frame_count, 4);

        // Over-long line fills the buffer early; surplus pixels are dropped.
        do_start();
        check("t7_err_cleared_by_start", line_err, 0);
        vsync_pulse();
        send_line(10, 0, 5);
        check("t7_err_after_long", line_err, 1);
        exp_done_q.push_back(1'b1);
        send_line(8, 5, 3);
        check("t7_addr_holds_last", DP_RAM_addr_in, 7);
        check("t7_fcount", frame_count, 5);

        // Continuous mode across three frames.
        do_reset();
        check("t5_fcount_after_reset", frame_count, 0);
        cont_mode = 1'b1;
        do_start();
        for (int f = 1; f <= 3; f++) begin
            vsync_pulse();
            exp_done_q.push_back(1'b0);
            send_line(8, 0, 4);
            if (f == 3) cont_mode = 1'b0;
            send_line(8, 4, 4);
            check("t5_fcount", frame_count, f);
            check("t5_busy", busy, (f < 3) ? 1 : 0);
        end

        // Abort with simultaneous start, on the cycle pixel 2 would be written.
        do_start();
        vsync_pulse();
        exp_q.push_back(AW'(0));
        exp_q.push_back(AW'(1));
        for (int i = 0; i < 10; i++) begin
            if (i == 6) begin
                drive(1'b0, 1'b1, 1'b1, 1'b1);
                @(negedge PCLK);
                check("t6_regw_on_abort", DP_RAM_regW, 0);
            end else begin
                drive(1'b0, 1'b1, 1'b0, 1'b0);
            end
            if (i == 7) begin
                @(negedge PCLK);
                check("t6_busy_after_abort", busy, 0);
            end
        end
        idle(4);
        check("t6_busy_stays_low", busy, 0);
        check("t6_fcount_kept", frame_count, 3);

        // Reset while armed, then a clean re-synchronised frame.
        do_start();
        check("t8_busy_armed", busy, 1);
        do_reset();
        check_all_zero("t8_reset_mid_arm");
        do_start();
        send_line(8, 0, 0);
        vsync_pulse();
        exp_done_q.push_back(1'b0);
        send_line(8, 0, 4);
        send_line(8, 4, 4);
        check("t8_fcount", frame_count, 1);

        idle(4);
        check("end_write_queue_empty", exp_q.size(), 0);
        check("end_done_queue_empty", exp_done_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
